// File: rtl/spi_frontend_pkg.sv
// ============================================================================
//  Module      : spi_frontend_pkg
//  Description : Shared opcodes, metadata table and state types for the SPI
//                command front end.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_frontend_pkg;

    localparam logic [7:0] OP_RESET       = 8'h00;
    localparam logic [7:0] OP_RUN         = 8'h01;
    localparam logic [7:0] OP_QUERY_ID    = 8'h02;
    localparam logic [7:0] OP_QUERY_META  = 8'h04;
    localparam logic [7:0] OP_QUERY_INPUT = 8'h06;

    localparam int LONG_CMD_BIT = 7;
    localparam int META_LEN     = 26;

    typedef enum logic [0:0] {
        META_IDLE = 1'b0,
        META_SEND = 1'b1
    } meta_state_t;

    // Device metadata: name, firmware version, sample memory, max rate, probes, protocol.
    function automatic logic [7:0] meta_byte(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:  b = 8'h01;
            5'd1:  b = 8'h4F;
            5'd2:  b = 8'h4C;
            5'd3:  b = 8'h53;
            5'd4:  b = 8'h00;
            5'd5:  b = 8'h02;
            5'd6:  b = 8'h33;
            5'd7:  b = 8'h2E;
            5'd8:  b = 8'h30;
            5'd9:  b = 8'h37;
            5'd10: b = 8'h00;
            5'd11: b = 8'h21;
            5'd12: b = 8'h00;
            5'd13: b = 8'h00;
            5'd14: b = 8'h60;
            5'd15: b = 8'h00;
            5'd16: b = 8'h23;
            5'd17: b = 8'h05;
            5'd18: b = 8'hF5;
            5'd19: b = 8'hE1;
            5'd20: b = 8'h00;
            5'd21: b = 8'h40;
            5'd22: b = 8'h20;
            5'd23: b = 8'h41;
            5'd24: b = 8'h02;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync_flops.sv
// ============================================================================
//  Module      : spi_sync_flops
//  Description : STAGES-deep synchronizer chain with configurable reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync_flops #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic extReset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or negedge extReset) begin
        if (!extReset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_cmd_frontend.sv
// ============================================================================
//  Module      : spi_cmd_frontend
//  Description : SPI slave receive front end: pin sync, SUMP command
//                deserializer, query decode and metadata streamer.
//                Metadata streamer built only with SPI_FRONTEND_META_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cmd_frontend
    import spi_frontend_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        extReset,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    input  logic        transmitting,
    input  logic        xmit_idle,
    output logic [7:0]  opcode,
    output logic [31:0] opdata,
    output logic [39:0] cmd,
    output logic        execute,
    output logic        query_id,
    output logic        query_metadata,
    output logic        query_dataIn,
    output logic        writeMeta,
    output logic [7:0]  meta_data
);

    logic       sync_sclk;
    logic       sync_cs;
    logic       sclk_prev;
    logic       sclk_rise;
    logic [2:0] bit_cnt;
    logic [2:0] byte_cnt;
    logic [7:0] shift;
    logic [7:0] shift_next;
    logic [7:0] op_pending;
    logic [31:0] data_acc;
    logic       execute_d;

    spi_sync_flops #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clock    (clock),
        .extReset (extReset),
        .d        (sclk),
        .q        (sync_sclk)
    );

    spi_sync_flops #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clock    (clock),
        .extReset (extReset),
        .d        (cs),
        .q        (sync_cs)
    );

    assign sclk_rise  = sync_sclk & ~sclk_prev;
    assign shift_next = {shift[6:0], mosi};
    assign cmd        = {opdata, opcode};

    // Opcode/opdata only update on a completed command; partial frames live in op_pending/data_acc.
    always_ff @(posedge clock or negedge extReset) begin
        if (!extReset) begin
            sclk_prev  <= 1'b0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 3'd0;
            shift      <= 8'h00;
            op_pending <= 8'h00;
            data_acc   <= 32'h0;
            opcode     <= 8'h00;
            opdata     <= 32'h0;
            execute    <= 1'b0;
        end else begin
            sclk_prev <= sync_sclk;
            execute   <= 1'b0;
            if (sync_cs) begin
                bit_cnt  <= 3'd0;
                byte_cnt <= 3'd0;
            end else if (!transmitting && sclk_rise) begin
                shift   <= shift_next;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (byte_cnt == 3'd0) begin
                        if (!shift_next[LONG_CMD_BIT]) begin
                            opcode  <= shift_next;
                            opdata  <= 32'h0;
                            execute <= 1'b1;
                        end else begin
                            op_pending <= shift_next;
                            byte_cnt   <= 3'd1;
                        end
                    end else begin
                        data_acc <= {shift_next, data_acc[31:8]};
                        if (byte_cnt == 3'd4) begin
                            opcode   <= op_pending;
                            opdata   <= {shift_next, data_acc[31:8]};
                            execute  <= 1'b1;
                            byte_cnt <= 3'd0;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge extReset) begin
        if (!extReset) begin
            execute_d      <= 1'b0;
            query_id       <= 1'b0;
            query_metadata <= 1'b0;
            query_dataIn   <= 1'b0;
        end else begin
            execute_d      <= execute;
            query_id       <= 1'b0;
            query_metadata <= 1'b0;
            query_dataIn   <= 1'b0;
            if (execute && !execute_d) begin
                query_id       <= (opcode == OP_QUERY_ID);
                query_metadata <= (opcode == OP_QUERY_META);
                query_dataIn   <= (opcode == OP_QUERY_INPUT);
            end
        end
    end

`ifdef SPI_FRONTEND_META_EN
    meta_state_t meta_state;
    logic [4:0]  meta_idx;

    // writeMeta gating forces at least one idle cycle between strobes.
    always_ff @(posedge clock or negedge extReset) begin
        if (!extReset) begin
            meta_state <= META_IDLE;
            meta_idx   <= 5'd0;
            writeMeta  <= 1'b0;
            meta_data  <= 8'h00;
        end else begin
            writeMeta <= 1'b0;
            case (meta_state)
                META_IDLE: begin
                    if (query_metadata) begin
                        meta_state <= META_SEND;
                        meta_idx   <= 5'd0;
                    end
                end
                META_SEND: begin
                    if (query_metadata) begin
                        meta_idx <= 5'd0;
                    end else if (xmit_idle && !writeMeta) begin
                        meta_data <= meta_byte(meta_idx);
                        writeMeta <= 1'b1;
                        meta_idx  <= meta_idx + 5'd1;
                        if (meta_idx == 5'(META_LEN - 1)) begin
                            meta_state <= META_IDLE;
                        end
                    end
                end
                default: meta_state <= META_IDLE;
            endcase
        end
    end
`else
    logic unused_xmit_idle;
    assign unused_xmit_idle = xmit_idle;
    assign writeMeta        = 1'b0;
    assign meta_data        = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_frontend.sv
// ============================================================================
//  Module      : tb_spi_cmd_frontend
//  Description : Directed self-checking bench for spi_cmd_frontend.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_cmd_frontend;

    logic        clock = 1'b0;
    logic        extReset = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        transmitting = 1'b0;
    logic        xmit_idle = 1'b1;
    logic [7:0]  opcode;
    logic [31:0] opdata;
    logic [39:0] cmd;
    logic        execute;
    logic        query_id;
    logic        query_metadata;
    logic        query_dataIn;
    logic        writeMeta;
    logic [7:0]  meta_data;

    int checks = 0;
    int errors = 0;

    // Monitor state, written only by the monitor process.
    int          cyc = 0;
    int          exec_count = 0;
    int          exec_cycle = 0;
    logic [7:0]  exec_op = 8'h00;
    logic [31:0] exec_data = 32'h0;
    logic [39:0] exec_cmd = 40'h0;
    int          qid_count = 0, qid_cycle = 0;
    int          qmeta_count = 0;
    int          qdata_count = 0, qdata_cycle = 0;
    logic [7:0]  meta_q[$];
    int          meta_cyc_q[$];

`ifdef SPI_FRONTEND_META_EN
    logic [7:0] exp_meta [26] = '{
        8'h01, 8'h4F, 8'h4C, 8'h53, 8'h00,
        8'h02, 8'h33, 8'h2E, 8'h30, 8'h37, 8'h00,
        8'h21, 8'h00, 8'h00, 8'h60, 8'h00,
        8'h23, 8'h05, 8'hF5, 8'hE1, 8'h00,
        8'h40, 8'h20, 8'h41, 8'h02, 8'h00};
`endif

    spi_cmd_frontend #(.SYNC_STAGES(2)) dut (
        .clock          (clock),
        .extReset       (extReset),
        .sclk           (sclk),
        .cs             (cs),
        .mosi           (mosi),
        .transmitting   (transmitting),
        .xmit_idle      (xmit_idle),
        .opcode         (opcode),
        .opdata         (opdata),
        .cmd            (cmd),
        .execute        (execute),
        .query_id       (query_id),
        .query_metadata (query_metadata),
        .query_dataIn   (query_dataIn),
        .writeMeta      (writeMeta),
        .meta_data      (meta_data)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (execute) begin
            exec_count = exec_count + 1;
            exec_cycle = cyc;
            exec_op    = opcode;
            exec_data  = opdata;
            exec_cmd   = cmd;
        end
        if (query_id) begin
            qid_count = qid_count + 1;
            qid_cycle = cyc;
        end
        if (query_metadata) qmeta_count = qmeta_count + 1;
        if (query_dataIn) begin
            qdata_count = qdata_count + 1;
            qdata_cycle = cyc;
        end
        if (writeMeta) begin
            meta_q.push_back(meta_data);
            meta_cyc_q.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    task automatic cs_low();
        @(negedge clock);
        cs = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic cs_high();
        @(negedge clock);
        cs = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clock);
            mosi = b[i];
            repeat (4) @(negedge clock);
            sclk = 1'b1;
            repeat (4) @(negedge clock);
            sclk = 1'b0;
        end
    endtask

    task automatic wait_meta(input int target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clock);
            if (meta_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        extReset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({opcode, opdata, cmd, execute, query_id, query_metadata, query_dataIn, writeMeta, meta_data} !== 93'h0) begin
            errors++;
            $display("FAIL reset_outputs: got opcode=%h opdata=%h cmd=%h exec=%b wm=%b md=%h, expected all 0",
                     opcode, opdata, cmd, execute, writeMeta, meta_data);
        end
        @(negedge clock);
        extReset = 1'b1;
        repeat (5) @(posedge clock);
        checks++;
        if (exec_count !== 0) begin
            errors++;
            $display("FAIL reset_no_exec: got %0d executes, expected 0", exec_count);
        end
    endtask

    task automatic test_short();
        int e0 = exec_count;
        int q0 = qid_count;
        int m0 = qmeta_count;
        cs_low();
        spi_byte(8'h02);
        cs_high();
        repeat (10) @(posedge clock);
        checks++;
        if (exec_count - e0 !== 1) begin
            errors++;
            $display("FAIL short_exec_count: got %0d, expected 1", exec_count - e0);
        end
        checks++;
        if (exec_cmd !== 40'h0000000002 || exec_op !== 8'h02 || exec_data !== 32'h0) begin
            errors++;
            $display("FAIL short_cmd: got cmd=%h op=%h data=%h, expected cmd=0000000002", exec_cmd, exec_op, exec_data);
        end
        checks++;
        if (qid_count - q0 !== 1 || qid_cycle !== exec_cycle + 1) begin
            errors++;
            $display("FAIL short_query_id: got count=%0d cycle=%0d, expected 1 at cycle %0d",
                     qid_count - q0, qid_cycle, exec_cycle + 1);
        end
        checks++;
        if (qmeta_count !== m0) begin
            errors++;
            $display("FAIL short_no_qmeta: got %0d, expected %0d", qmeta_count, m0);
        end
    endtask

    task automatic test_long();
        int e0 = exec_count;
        int q0 = qid_count + qmeta_count + qdata_count;
        cs_low();
        spi_byte(8'h80);
        spi_byte(8'h11);
        spi_byte(8'h22);
        spi_byte(8'h33);
        spi_byte(8'h44);
        cs_high();
        repeat (10) @(posedge clock);
        checks++;
        if (exec_count - e0 !== 1) begin
            errors++;
            $display("FAIL long_exec_count: got %0d, expected 1", exec_count - e0);
        end
        checks++;
        if (exec_data !== 32'h44332211 || exec_cmd !== 40'h4433221180) begin
            errors++;
            $display("FAIL long_cmd: got data=%h cmd=%h, expected data=44332211 cmd=4433221180", exec_data, exec_cmd);
        end
        checks++;
        if (qid_count + qmeta_count + qdata_count !== q0) begin
            errors++;
            $display("FAIL long_no_query: got %0d query pulses, expected 0", qid_count + qmeta_count + qdata_count - q0);
        end
    endtask

    task automatic test_abort();
        int e0 = exec_count;
        int d0 = qdata_count;
        cs_low();
        spi_byte(8'h80);
        spi_byte(8'hAA);
        cs_high();
        repeat (10) @(posedge clock);
        checks++;
        if (exec_count !== e0 || opcode !== 8'h80 || opdata !== 32'h44332211) begin
            errors++;
            $display("FAIL abort_hold: got execs=%0d opcode=%h opdata=%h, expected 0 execs 80/44332211",
                     exec_count - e0, opcode, opdata);
        end
        cs_low();
        spi_byte(8'h06);
        cs_high();
        repeat (10) @(posedge clock);
        checks++;
        if (exec_count - e0 !== 1 || exec_op !== 8'h06 || exec_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_next: got execs=%0d op=%h data=%h, expected 1 exec op=06 data=0",
                     exec_count - e0, exec_op, exec_data);
        end
        checks++;
        if (qdata_count - d0 !== 1 || qdata_cycle !== exec_cycle + 1) begin
            errors++;
            $display("FAIL abort_query_dataIn: got count=%0d cycle=%0d, expected 1 at cycle %0d",
                     qdata_count - d0, qdata_cycle, exec_cycle + 1);
        end
    endtask

    task automatic test_transmitting();
        int e0 = exec_count;
        transmitting = 1'b1;
        cs_low();
        spi_byte(8'h04);
        cs_high();
        transmitting = 1'b0;
        repeat (10) @(posedge clock);
        checks++;
        if (exec_count !== e0 || opcode !== 8'h06) begin
            errors++;
            $display("FAIL transmitting_ignore: got execs=%0d opcode=%h, expected 0 execs opcode=06",
                     exec_count - e0, opcode);
        end
    endtask

    task automatic test_metadata();
        int base = meta_q.size();
        int m0 = qmeta_count;
        bit ok;
        xmit_idle = 1'b1;
        cs_low();
        spi_byte(8'h04);
        cs_high();
`ifdef SPI_FRONTEND_META_EN
        wait_meta(base + 26, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL meta_count: got %0d strobes, expected 26", meta_q.size() - base);
        end else begin
            for (int i = 0; i < 26; i++) begin
                checks++;
                if (meta_q[base + i] !== exp_meta[i]) begin
                    errors++;
                    $display("FAIL meta_byte[%0d]: got %h, expected %h", i, meta_q[base + i], exp_meta[i]);
                end
            end
            for (int i = 1; i < 26; i++) begin
                checks++;
                if (meta_cyc_q[base + i] - meta_cyc_q[base + i - 1] !== 2) begin
                    errors++;
                    $display("FAIL meta_spacing[%0d]: got %0d cycles, expected 2", i,
                             meta_cyc_q[base + i] - meta_cyc_q[base + i - 1]);
                end
            end
        end
        repeat (40) @(posedge clock);
        checks++;
        if (meta_q.size() !== base + 26) begin
            errors++;
            $display("FAIL meta_idle_after: got %0d strobes, expected 26", meta_q.size() - base);
        end
        // Same table with a randomly stalling transmitter.
        base = meta_q.size();
        cs_low();
        spi_byte(8'h04);
        cs_high();
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clock);
            if (meta_q.size() >= base + 26) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
            xmit_idle = 1'($urandom_range(0, 1));
        end
        xmit_idle = 1'b1;
        repeat (40) @(posedge clock);
        checks++;
        if (!ok || meta_q.size() !== base + 26) begin
            errors++;
            $display("FAIL meta_random_count: got %0d strobes, expected 26", meta_q.size() - base);
        end else begin
            for (int i = 0; i < 26; i++) begin
                checks++;
                if (meta_q[base + i] !== exp_meta[i]) begin
                    errors++;
                    $display("FAIL meta_random_byte[%0d]: got %h, expected %h", i, meta_q[base + i], exp_meta[i]);
                end
            end
        end
`else
        repeat (60) @(posedge clock);
        ok = 1'b1;
        checks++;
        if (!ok || meta_q.size() !== base || meta_data !== 8'h00) begin
            errors++;
            $display("FAIL meta_disabled: got %0d strobes meta_data=%h, expected 0 strobes and 00",
                     meta_q.size() - base, meta_data);
        end
`endif
        checks++;
        if (qmeta_count - m0 < 1) begin
            errors++;
            $display("FAIL meta_query_pulse: got %0d query_metadata pulses, expected at least 1", qmeta_count - m0);
        end
    endtask

    task automatic test_reset_mid();
        int base = meta_q.size();
        int m0;
        bit ok;
        xmit_idle = 1'b1;
        cs_low();
        spi_byte(8'h04);
        cs_high();
`ifdef SPI_FRONTEND_META_EN
        wait_meta(base + 5, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_meta_started: got %0d strobes, expected at least 5", meta_q.size() - base);
        end
`endif
        @(negedge clock);
        #2 extReset = 1'b0;
        #1;
        checks++;
        if ({opcode, opdata, execute, query_id, query_metadata, query_dataIn, writeMeta, meta_data} !== 53'h0) begin
            errors++;
            $display("FAIL rst_mid_meta: got opcode=%h opdata=%h wm=%b md=%h, expected all 0",
                     opcode, opdata, writeMeta, meta_data);
        end
        repeat (3) @(negedge clock);
        extReset = 1'b1;
        base = meta_q.size();
        repeat (40) @(posedge clock);
        checks++;
        if (meta_q.size() !== base) begin
            errors++;
            $display("FAIL rst_meta_idle: got %0d strobes after reset, expected 0", meta_q.size() - base);
        end
        cs_low();
        spi_byte(8'h06);
        cs_high();
        repeat (5) @(posedge clock);
        cs_low();
        spi_byte(8'h80);
        spi_byte(8'h11);
        @(negedge clock);
        #2 extReset = 1'b0;
        #1;
        checks++;
        if ({opcode, opdata, cmd, execute, writeMeta, meta_data} !== 90'h0) begin
            errors++;
            $display("FAIL rst_mid_long: got opcode=%h opdata=%h cmd=%h, expected all 0", opcode, opdata, cmd);
        end
        repeat (3) @(negedge clock);
        extReset = 1'b1;
        cs_high();
        base = meta_q.size();
        m0 = qmeta_count;
        cs_low();
        spi_byte(8'h04);
        cs_high();
        repeat (10) @(posedge clock);
        checks++;
        if (qmeta_count - m0 !== 1 || opcode !== 8'h04) begin
            errors++;
            $display("FAIL rst_requery: got pulses=%0d opcode=%h, expected 1 and 04", qmeta_count - m0, opcode);
        end
`ifdef SPI_FRONTEND_META_EN
        wait_meta(base + 26, ok);
        checks++;
        if (!ok || meta_q[base] !== 8'h01 || meta_q[base + 25] !== 8'h00) begin
            errors++;
            $display("FAIL rst_meta_restart: got %0d strobes, first=%h, expected 26 starting 01",
                     meta_q.size() - base, (meta_q.size() > base) ? meta_q[base] : 8'hxx);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_abort();
        test_transmitting();
        test_metadata();
        test_reset_mid();
        repeat (10) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_cmd_frontend.md
Name: spi_cmd_frontend

Overview:
- Receive-side front end of the SPI slave for the SUMP-compatible logic analyzer.
- Synchronizes the raw SPI pins into the `clock` domain and deserializes SUMP short and long commands.
- Decodes the query commands handled outside the core decoder.
- Streams the device metadata table to the SPI transmitter one byte at a time.

Parameters:
- SYNC_STAGES, 2, number of flops in each of the sclk and cs synchronizers; minimum 2.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- extReset  in  1  asynchronous, active-low reset.
- sclk  in  1  raw SPI clock (mode 0).
- cs  in  1  raw SPI chip select, active low.
- mosi  in  1  SPI data in. Sampled on the synchronized sclk rising edge; no separate synchronizer.
- transmitting  in  1  transmitter busy; receiver ignores incoming bits while high.
- xmit_idle  in  1  transmitter can accept one metadata byte.
- opcode  out  8  last received command opcode.
- opdata  out  32  last received command data.
- cmd  out  40  {opdata, opcode}.
- execute  out  1  one-cycle pulse when a command completes.
- query_id  out  1  one-cycle pulse for opcode 0x02.
- query_metadata  out  1  one-cycle pulse for opcode 0x04.
- query_dataIn  out  1  one-cycle pulse for opcode 0x06.
- writeMeta  out  1  one-cycle strobe; meta_data is valid while it is high.
- meta_data  out  8  current metadata byte.

Behaviour:
- Reset values:
  - All outputs 0.
  - sclk synchronizer flops 0; cs synchronizer flops 1.
  - Bit counter, byte counter and metadata index 0; metadata engine idle.
- Synchronizer: SYNC_STAGES-deep flop chain per input, giving sync_sclk and sync_cs.
- sclk edge detect: register sync_sclk; a rising edge is sync_sclk=1 with the previous value 0.
- Receiver, bit sampling:
  - While sync_cs=1, bit and byte counters clear and any partial command is discarded.
  - While sync_cs=0 and transmitting=0, each sclk rising edge shifts in mosi, MSB first.
- Receiver, command assembly:
  - Byte 0 is the opcode.
  - opcode[7]=0 is a short command: opdata is cleared to 0 and execute pulses 1 clock after the 8th bit.
  - opcode[7]=1 is a long command: 4 further bytes follow. Each completed byte shifts in as opdata={byte, opdata[31:8]}, so the first data byte ends up in opdata[7:0]. execute pulses 1 clock after the 40th bit.
  - opcode and opdata hold their values until the next command completes.
  - A cs rise mid-command aborts it: no execute, and outputs keep their previous values.
- Query decode:
  - Register a delayed copy of execute.
  - On the execute rising edge (execute=1, delayed=0), decode opcode: 0x02 sets query_id, 0x04 sets query_metadata, 0x06 sets query_dataIn.
  - Each query output is a registered one-cycle pulse, 1 clock after execute. Other opcodes produce none.
- Metadata engine:
  - States: IDLE, SEND.
  - query_metadata moves IDLE→SEND with the index at 0. If it arrives while already in SEND, the index restarts at 0.
  - In SEND, each clock with xmit_idle=1 and writeMeta=0 (the previous cycle): drive meta_data=ROM[index], pulse writeMeta for one cycle, and increment the index.
  - After the terminating 0x00 entry (index 25) is sent, return to IDLE.
  - ROM, 26 bytes, in order:
    - 0x01 'O' 'L' 'S' 0x00
    - 0x02 '3' '.' '0' '7' 0x00
    - 0x21 0x00 0x00 0x60 0x00
    - 0x23 0x05 0xF5 0xE1 0x00
    - 0x40 0x20
    - 0x41 0x02
    - 0x00
- Reset asserted mid-operation returns every state machine to its idle or reset state immediately.

Optional Feature:
- Macro: SPI_FRONTEND_META_EN.
- Defined: the metadata engine and ROM are built as above.
- Undefined: the engine is omitted and writeMeta and meta_data are tied to 0. query_metadata is still decoded and pulsed.

Decomposition:
- Shared package spi_frontend_pkg holds:
  - opcode constants OP_RESET=0x00, OP_RUN=0x01, OP_QUERY_ID=0x02, OP_QUERY_META=0x04, OP_QUERY_INPUT=0x06;
  - LONG_CMD_BIT=7;
  - META_LEN=26;
  - the metadata ROM contents;
  - the metadata state enum.
- One sub-module, spi_sync_flops, is the SYNC_STAGES flop chain with a reset-value parameter. It is instantiated twice, for sclk and cs.

Test Plan:
- Short command: cs low, send 0x02, cs high → execute pulse with opcode=0x02, opdata=0, cmd=0x0000000002; query_id pulses exactly 1 clock after execute.
- Long command: send 0x80, 0x11, 0x22, 0x33, 0x44 → single execute after the 40th bit with opdata=0x44332211, cmd=0x4433221180; no query pulse.
- Abort: send 0x80, 0xAA, then raise cs, then send 0x06 → only one execute, with opcode=0x06 and opdata=0; query_dataIn pulses.
- transmitting=1 while 0x04 is clocked in → no execute and opcode unchanged.
- Metadata: send 0x04, hold xmit_idle=1 → 26 writeMeta strobes on alternate clocks, bytes 0x01, 0x4F … 0x02, 0x00; engine returns to IDLE. With xmit_idle toggled randomly, the same sequence appears with no loss or duplication.
- Reset: pull extReset low mid-metadata and mid-long-command → all outputs 0 immediately; the next 0x04 restarts the sequence at 0x01.
